// File: rtl/float64_to_int_iter_pkg.sv
// Shared FLOAT64 field positions, saturation constants, FSM states and
// funcSelect encoding for the float-to-integer conversion path.
package fpu_f64_pkg;

    localparam int CONST_NUM_BASE = 0;
    localparam int CONST_EXP_BASE = 52;
    localparam int CONST_SIG_BASE = 63;

    localparam int          EXP_BIAS    = 1023;
    localparam logic [10:0] EXP_SPECIAL = 11'd2047;

    localparam logic [63:0] INT64_MAX  = 64'h7FFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] INT64_MIN  = 64'h8000_0000_0000_0000;
    localparam logic [63:0] UINT64_MAX = 64'hFFFF_FFFF_FFFF_FFFF;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DECODE = 3'd1,
        SHIFT  = 3'd2,
        ROUND  = 3'd3,
        DONE   = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        FS_I64_TRUNC = 2'd0,
        FS_U64_TRUNC = 2'd1,
        FS_I64_RNE   = 2'd2,
        FS_U64_RNE   = 2'd3
    } func_sel_t;

    function automatic logic fs_is_unsigned(input logic [1:0] fs);
        return fs[0];
    endfunction

    function automatic logic fs_is_rne(input logic [1:0] fs);
        return fs[1];
    endfunction

endpackage

// File: rtl/float64_to_int_iter_round.sv
// Final rounding, sign application and saturation of the shifted magnitude.
module f64_int_round
    import fpu_f64_pkg::*;
(
    input  logic [63:0] int_val,
    input  logic        guard,
    input  logic        sticky,
    input  logic        sign,
    input  logic        rne,
    input  logic        is_unsigned,
    output logic [63:0] result,
    output logic        is_error,
    output logic        is_inexact
);

    logic        inc_s;
    logic [64:0] mag_s;

    // round the magnitude, then map it into the target integer range
    always_comb begin
        inc_s      = rne & guard & (sticky | int_val[0]);
        mag_s      = {1'b0, int_val} + {64'd0, inc_s};
        is_inexact = guard | sticky;
        result     = 64'd0;
        is_error   = 1'b0;
        if (is_unsigned) begin
            if (sign) begin
                result   = 64'd0;
                is_error = (mag_s != 65'd0);
            end else if (mag_s[64]) begin
                result   = UINT64_MAX;
                is_error = 1'b1;
            end else begin
                result   = mag_s[63:0];
                is_error = 1'b0;
            end
        end else begin
            if (!sign && (mag_s > {1'b0, INT64_MAX})) begin
                result   = INT64_MAX;
                is_error = 1'b1;
            end else if (sign && (mag_s > {1'b0, INT64_MIN})) begin
                result   = INT64_MIN;
                is_error = 1'b1;
            end else if (sign) begin
                result   = ~mag_s[63:0] + 64'd1;
                is_error = 1'b0;
            end else begin
                result   = mag_s[63:0];
                is_error = 1'b0;
            end
        end
    end

endmodule

// File: rtl/float64_to_int_iter.sv
// Multi-cycle FLOAT64 -> INT64/UINT64 converter: decode, iterative shift of
// at most SHIFT_STEP bits per cycle, then round/saturate.
module float64_to_int_iter
    import fpu_f64_pkg::*;
#(
    parameter int SHIFT_STEP = 8,
    parameter int EXP_BIAS   = 1023
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clean,
    input  logic        start,
    input  logic [63:0] numA,
    input  logic [63:0] numB,
    output logic [63:0] numC,
    output logic        isNowTickReady,
    input  logic [1:0]  funcSelect,
    output logic        isBusy,
    output logic        isError,
    output logic        isInexact
);

    localparam logic [6:0] STEP = 7'(SHIFT_STEP);

    state_t             state_q, state_d;
    logic [63:0]        opb_q, opb_d;
    logic [1:0]         fs_q, fs_d;
    logic [63:0]        work_q, work_d;
    logic               guard_q, guard_d, sticky_q, sticky_d;
    logic [6:0]         rem_q, rem_d;
    logic               left_q, left_d;
    logic [63:0]        numc_q, numc_d;
    logic               ready_q, ready_d, busy_q, busy_d;
    logic               err_q, err_d, inx_q, inx_d;

    logic               sign_s;
    logic [10:0]        exp_s;
    logic [51:0]        frac_s;
    logic signed [12:0] unb_exp_s;
    logic               is_nan_s, is_inf_s, is_zero_s, is_ovf_s, special_s;
    logic [6:0]         amt_s;
    logic               amt_left_s;
    logic [63:0]        spec_res_s;
    logic [6:0]         step_s;
    logic [127:0]       rsh_s;
    logic [63:0]        rnd_res_s;
    logic               rnd_err_s, rnd_inx_s;
    logic               unused_numa_s;

    assign unused_numa_s = ^numA;

    // field decode, classification and shift distance of the latched operand
    always_comb begin
        sign_s     = opb_q[CONST_SIG_BASE];
        exp_s      = opb_q[CONST_SIG_BASE-1:CONST_EXP_BASE];
        frac_s     = opb_q[CONST_EXP_BASE-1:CONST_NUM_BASE];
        unb_exp_s  = $signed({2'b00, exp_s}) - $signed(13'(EXP_BIAS));
        is_nan_s   = (exp_s == EXP_SPECIAL) && (frac_s != 52'd0);
        is_inf_s   = (exp_s == EXP_SPECIAL) && (frac_s == 52'd0);
        is_zero_s  = (exp_s == 11'd0) && (frac_s == 52'd0);
        if (unb_exp_s >= 13'sd64) begin
            is_ovf_s = 1'b1;
        end else if (!fs_is_unsigned(fs_q) && (unb_exp_s == 13'sd63)) begin
            is_ovf_s = !(sign_s && (frac_s == 52'd0));
        end else begin
            is_ovf_s = 1'b0;
        end
        special_s = is_nan_s | is_inf_s | is_zero_s | is_ovf_s;
        if (unb_exp_s >= 13'sd52) begin
            amt_left_s = 1'b1;
            amt_s      = 7'(unb_exp_s - 13'sd52);
        end else if (unb_exp_s < -13'sd12) begin
            amt_left_s = 1'b0;
            amt_s      = 7'd64;
        end else begin
            amt_left_s = 1'b0;
            amt_s      = 7'(13'sd52 - unb_exp_s);
        end
        if (is_nan_s) begin
            spec_res_s = fs_is_unsigned(fs_q) ? UINT64_MAX : INT64_MAX;
        end else if (is_zero_s) begin
            spec_res_s = 64'd0;
        end else if (sign_s) begin
            spec_res_s = fs_is_unsigned(fs_q) ? 64'd0 : INT64_MIN;
        end else begin
            spec_res_s = fs_is_unsigned(fs_q) ? UINT64_MAX : INT64_MAX;
        end
    end

    // bits moved this SHIFT cycle; low half of rsh_s holds what fell out
    always_comb begin
        if (rem_q < STEP) begin
            step_s = rem_q;
        end else begin
            step_s = STEP;
        end
        rsh_s = {work_q, 64'd0} >> step_s;
    end

    f64_int_round u_round (
        .int_val     (work_q),
        .guard       (guard_q),
        .sticky      (sticky_q),
        .sign        (opb_q[CONST_SIG_BASE]),
        .rne         (fs_is_rne(fs_q)),
        .is_unsigned (fs_is_unsigned(fs_q)),
        .result      (rnd_res_s),
        .is_error    (rnd_err_s),
        .is_inexact  (rnd_inx_s)
    );

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // next-state logic; clean overrides every transition
    always_comb begin
        state_d = state_q;
        if (clean) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    state_d = start ? DECODE : IDLE;
                DECODE:  begin
                    if (special_s) begin
                        state_d = DONE;
                    end else if (amt_s == 7'd0) begin
                        state_d = ROUND;
                    end else begin
                        state_d = SHIFT;
                    end
                end
                SHIFT:   state_d = (rem_q <= STEP) ? ROUND : SHIFT;
                ROUND:   state_d = DONE;
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // datapath and output next values
    always_comb begin
        opb_d    = opb_q;
        fs_d     = fs_q;
        work_d   = work_q;
        guard_d  = guard_q;
        sticky_d = sticky_q;
        rem_d    = rem_q;
        left_d   = left_q;
        numc_d   = numc_q;
        err_d    = err_q;
        inx_d    = inx_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    opb_d = numB;
                    fs_d  = funcSelect;
                end else begin
                    opb_d = opb_q;
                    fs_d  = fs_q;
                end
            end
            DECODE: begin
                work_d   = {11'd0, (exp_s != 11'd0), frac_s};
                guard_d  = 1'b0;
                sticky_d = 1'b0;
                rem_d    = amt_s;
                left_d   = amt_left_s;
            end
            SHIFT: begin
                rem_d = rem_q - step_s;
                if (left_q) begin
                    work_d = work_q << step_s;
                end else begin
                    work_d   = rsh_s[127:64];
                    guard_d  = rsh_s[63];
                    sticky_d = sticky_q | guard_q | (|rsh_s[62:0]);
                end
            end
            default: begin
                work_d = work_q;
            end
        endcase
        if (state_d == DONE) begin
            if (state_q == DECODE) begin
                numc_d = spec_res_s;
                err_d  = !is_zero_s;
                inx_d  = 1'b0;
            end else begin
                numc_d = rnd_res_s;
                err_d  = rnd_err_s;
                inx_d  = rnd_inx_s;
            end
        end else begin
            numc_d = numc_q;
        end
        ready_d = (state_d == DONE);
        busy_d  = (state_d != IDLE);
    end

    // working and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            opb_q    <= 64'd0;
            fs_q     <= 2'd0;
            work_q   <= 64'd0;
            guard_q  <= 1'b0;
            sticky_q <= 1'b0;
            rem_q    <= 7'd0;
            left_q   <= 1'b0;
            numc_q   <= 64'd0;
            ready_q  <= 1'b0;
            busy_q   <= 1'b0;
            err_q    <= 1'b0;
            inx_q    <= 1'b0;
        end else begin
            opb_q    <= opb_d;
            fs_q     <= fs_d;
            work_q   <= work_d;
            guard_q  <= guard_d;
            sticky_q <= sticky_d;
            rem_q    <= rem_d;
            left_q   <= left_d;
            numc_q   <= numc_d;
            ready_q  <= ready_d;
            busy_q   <= busy_d;
            err_q    <= err_d;
            inx_q    <= inx_d;
        end
    end

    assign numC           = numc_q;
    assign isNowTickReady = ready_q;
    assign isBusy         = busy_q;
    assign isError        = err_q;
    assign isInexact      = inx_q;

endmodule

// File: tb/tb_float64_to_int_iter.sv
// Scoreboard bench: expected results are queued at issue time and checked by
// a monitor whenever the converter pulses isNowTickReady.
module tb_float64_to_int_iter;

    localparam logic [63:0] MAX  = 64'h7FFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] MIN  = 64'h8000_0000_0000_0000;
    localparam logic [63:0] UMAX = 64'hFFFF_FFFF_FFFF_FFFF;

    logic        clk = 1'b0, rst = 1'b1, clean = 1'b0, start = 1'b0;
    logic [63:0] numA = 64'd0, numB = 64'd0, numC;
    logic [1:0]  funcSelect = 2'd0;
    logic        isNowTickReady, isBusy, isError, isInexact;

    typedef struct {
        logic [63:0] res;
        logic        err;
        logic        inx;
        int          lat;
        int          ecyc;
    } exp_t;

    exp_t        sb[$];
    int          total = 0, bad = 0, cyc = 0;
    logic [63:0] last_res = 64'd0;

    float64_to_int_iter dut (
        .clk(clk), .rst(rst), .clean(clean), .start(start),
        .numA(numA), .numB(numB), .numC(numC),
        .isNowTickReady(isNowTickReady), .funcSelect(funcSelect),
        .isBusy(isBusy), .isError(isError), .isInexact(isInexact)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Value-level reference: exact integer/fraction split, then range rules.
    function automatic exp_t model(input logic [63:0] b, input logic [1:0] fs);
        exp_t         r;
        logic         s, uns, rne;
        int           e, ee, sh, ue, rs;
        logic [51:0]  f;
        logic [127:0] m, ip, rm, one, twice;
        logic [63:0]  lo;
        bit           big;
        s = b[63]; e = int'(b[62:52]); f = b[51:0]; uns = fs[0]; rne = fs[1];
        r.res = 64'd0; r.err = 1'b0; r.inx = 1'b0; r.ecyc = 0;
        ue = e - 1023;
        if (e == 2047 || (e == 0 && f == 52'd0) || ue >= 64 ||
            (!uns && ue >= 63 && !(s && ue == 63 && f == 52'd0))) r.lat = 2;
        else if (ue >= 52) r.lat = 3 + (ue - 52 + 7) / 8;
        else begin
            rs = 52 - ue;
            if (rs > 64) rs = 64;
            r.lat = 3 + (rs + 7) / 8;
        end
        if (e == 2047) begin
            r.err = 1'b1;
            if (f != 52'd0) r.res = uns ? UMAX : MAX;
            else r.res = s ? (uns ? 64'd0 : MIN) : (uns ? UMAX : MAX);
            return r;
        end
        m  = {75'd0, (e != 0), f};
        ee = (e == 0) ? -1022 : e - 1023;
        sh = 52 - ee;
        big = 1'b0; ip = 128'd0;
        if (sh <= 0) begin
            if (-sh > 60) big = 1'b1;
            else ip = m << (-sh);
        end else if (sh >= 100) begin
            r.inx = (m != 128'd0);
        end else begin
            ip    = m >> sh;
            rm    = m - (ip << sh);
            one   = 128'd1 << sh;
            twice = rm << 1;
            r.inx = (rm != 128'd0);
            if (rne && (twice > one || (twice == one && ip[0]))) ip = ip + 128'd1;
        end
        lo = ip[63:0];
        if (uns) begin
            if (s) r.err = big || (ip != 128'd0);
            else if (big || ip > 128'hFFFF_FFFF_FFFF_FFFF) begin r.res = UMAX; r.err = 1'b1; end
            else r.res = lo;
        end else begin
            if (!s && (big || ip > 128'h7FFF_FFFF_FFFF_FFFF)) begin r.res = MAX; r.err = 1'b1; end
            else if (s && (big || ip > 128'h8000_0000_0000_0000)) begin r.res = MIN; r.err = 1'b1; end
            else r.res = s ? (64'd0 - lo) : lo;
        end
        return r;
    endfunction

    task automatic issue(input logic [63:0] b, input logic [1:0] fs, input bit track, input exp_t e);
        @(negedge clk);
        numB = b; funcSelect = fs; start = 1'b1;
        if (track) begin
            e.ecyc = cyc + e.lat;
            sb.push_back(e);
            last_res = e.res;
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (isBusy === 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("idle_wait", {63'd0, isBusy}, 64'd0);
    endtask

    typedef struct {
        logic [63:0] b;
        logic [1:0]  fs;
        logic [63:0] res;
        logic        err;
        logic        inx;
        int          lat;
    } vec_t;

    vec_t dir[16] = '{
        '{64'h4059_0000_0000_0000, 2'd0, 64'h64,                   1'b0, 1'b0, 9},
        '{64'h4004_0000_0000_0000, 2'd2, 64'h2,                    1'b0, 1'b1, 10},
        '{64'h400C_0000_0000_0000, 2'd2, 64'h4,                    1'b0, 1'b1, 10},
        '{64'hC004_0000_0000_0000, 2'd0, 64'hFFFF_FFFF_FFFF_FFFE,  1'b0, 1'b1, 10},
        '{64'h7FF8_0000_0000_0001, 2'd0, MAX,                      1'b1, 1'b0, 2},
        '{64'h7FF8_0000_0000_0001, 2'd1, UMAX,                     1'b1, 1'b0, 2},
        '{64'hC3E0_0000_0000_0000, 2'd0, MIN,                      1'b0, 1'b0, 5},
        '{64'h43E0_0000_0000_0000, 2'd0, MAX,                      1'b1, 1'b0, 2},
        '{64'h43E0_0000_0000_0000, 2'd1, MIN,                      1'b0, 1'b0, 5},
        '{64'hBFF0_0000_0000_0000, 2'd1, 64'h0,                    1'b1, 1'b0, 10},
        '{64'hBFD0_0000_0000_0000, 2'd3, 64'h0,                    1'b0, 1'b1, 10},
        '{64'h7FF0_0000_0000_0000, 2'd0, MAX,                      1'b1, 1'b0, 2},
        '{64'hFFF0_0000_0000_0000, 2'd2, MIN,                      1'b1, 1'b0, 2},
        '{64'h0000_0000_0000_0000, 2'd3, 64'h0,                    1'b0, 1'b0, 2},
        '{64'h4330_0000_0000_0000, 2'd0, 64'h0010_0000_0000_0000,  1'b0, 1'b0, 3},
        '{64'h3FF8_0000_0000_0000, 2'd2, 64'h2,                    1'b0, 1'b1, 10}
    };

    initial begin
        exp_t        e;
        logic [63:0] rv, b;
        logic [51:0] f;
        logic [10:0] ex;
        logic [1:0]  fs;

        fork
            forever begin
                exp_t x;
                @(negedge clk);
                if (!rst && isNowTickReady === 1'b1) begin
                    if (sb.size() == 0) begin
                        total++; bad++;
                        $display("FAIL unexpected_ready: got 1 expected 0 at cycle %0d", cyc);
                    end else begin
                        x = sb.pop_front();
                        chk("numC", numC, x.res);
                        chk("isError", {63'd0, isError}, {63'd0, x.err});
                        chk("isInexact", {63'd0, isInexact}, {63'd0, x.inx});
                        chk("ready_cycle", 64'(cyc), 64'(x.ecyc));
                        chk("busy_at_ready", {63'd0, isBusy}, 64'd1);
                    end
                end
            end
        join_none

        repeat (3) @(negedge clk);
        chk("reset_numC", numC, 64'd0);
        chk("reset_ready", {63'd0, isNowTickReady}, 64'd0);
        chk("reset_busy", {63'd0, isBusy}, 64'd0);
        chk("reset_err", {63'd0, isError}, 64'd0);
        chk("reset_inx", {63'd0, isInexact}, 64'd0);
        rst = 1'b0;
        @(negedge clk);

        foreach (dir[i]) begin
            e.res = dir[i].res; e.err = dir[i].err; e.inx = dir[i].inx; e.lat = dir[i].lat; e.ecyc = 0;
            issue(dir[i].b, dir[i].fs, 1'b1, e);
            chk("busy_after_start", {63'd0, isBusy}, 64'd1);
            wait_idle();
        end

        // clean during SHIFT: no pulse, result unchanged
        issue(64'h4059_0000_0000_0000, 2'd1, 1'b0, e);
        @(negedge clk);
        clean = 1'b1;
        @(negedge clk);
        clean = 1'b0;
        chk("clean_idle", {63'd0, isBusy}, 64'd0);
        repeat (12) @(negedge clk);
        chk("clean_hold_numC", numC, last_res);

        // clean together with start in IDLE
        numB = 64'h4059_0000_0000_0000; start = 1'b1; clean = 1'b1;
        @(negedge clk);
        start = 1'b0; clean = 1'b0;
        chk("clean_start_idle", {63'd0, isBusy}, 64'd0);

        // start while busy is ignored
        e.res = 64'h2; e.err = 1'b0; e.inx = 1'b1; e.lat = 10;
        issue(64'h4004_0000_0000_0000, 2'd2, 1'b1, e);
        @(negedge clk);
        numB = 64'h4059_0000_0000_0000; funcSelect = 2'd0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_idle();
        repeat (12) @(negedge clk);
        chk("busy_start_idle", {63'd0, isBusy}, 64'd0);

        // asynchronous reset in the middle of SHIFT
        issue(64'hC004_0000_0000_0000, 2'd0, 1'b0, e);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_numC", numC, 64'd0);
        chk("rst_ready", {63'd0, isNowTickReady}, 64'd0);
        chk("rst_busy", {63'd0, isBusy}, 64'd0);
        chk("rst_err", {63'd0, isError}, 64'd0);
        chk("rst_inx", {63'd0, isInexact}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        last_res = 64'd0;
        @(negedge clk);

        for (int k = 0; k < 300; k++) begin
            rv = {$urandom, $urandom};
            f  = rv[51:0];
            case ($urandom_range(0, 9))
                0:       begin ex = 11'd2047; if ($urandom_range(0, 1) == 0) f = 52'd0; end
                1:       begin ex = 11'd0; if ($urandom_range(0, 1) == 0) f = 52'd0; end
                2:       begin ex = 11'(1021 + $urandom_range(0, 8)); f = f & 52'hFF_0000_0000_000; end
                default: ex = 11'(1003 + $urandom_range(0, 90));
            endcase
            fs = 2'($urandom_range(0, 3));
            b  = {1'($urandom_range(0, 1)), ex, f};
            e  = model(b, fs);
            issue(b, fs, 1'b1, e);
            wait_idle();
        end

        repeat (5) @(negedge clk);
        chk("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
